// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC iteration core and its gain-compensation stage.
package cordic_pkg;

  localparam int Q_W    = 32;
  localparam int Q_FRAC = 16;

  typedef enum logic [1:0] {
    CIRCULAR   = 2'b00,
    LINEAR     = 2'b01,
    HYPERBOLIC = 2'b10,
    RESERVED   = 2'b11
  } mode_e;

  localparam logic [Q_W-1:0] GAIN_CIRC_Q16  = 32'h0000_9B75;
  localparam logic [Q_W-1:0] GAIN_HYPER_Q16 = 32'h0001_351E;
  localparam logic [Q_W-1:0] GAIN_UNITY_Q16 = 32'h0001_0000;

  typedef struct packed {
    mode_e          mode;
    logic           sat;
    logic [Q_W-1:0] x;
    logic [Q_W-1:0] y;
    logic [Q_W-1:0] z;
  } result_t;

endpackage

// File: rtl/cordic_gain_comp_if.sv
// Result strobe from the CORDIC core in, compensated results out behind valid/ready.
interface cordic_gain_comp_if;
  logic        valid_i;
  logic [1:0]  mode_i;
  logic [31:0] x_i;
  logic [31:0] y_i;
  logic [31:0] z_i;
  logic        ready_i;
  logic        valid_o;
  logic [31:0] x_o;
  logic [31:0] y_o;
  logic [31:0] z_o;
  logic [1:0]  mode_o;
  logic        sat_o;
  logic        overflow_o;

  modport slave (
    input  valid_i, mode_i, x_i, y_i, z_i, ready_i,
    output valid_o, x_o, y_o, z_o, mode_o, sat_o, overflow_o
  );

  modport master (
    output valid_i, mode_i, x_i, y_i, z_i, ready_i,
    input  valid_o, x_o, y_o, z_o, mode_o, sat_o, overflow_o
  );
endinterface

// File: rtl/cordic_result_fifo.sv
// First-word-fall-through FIFO of packed CORDIC results; drops pushes when full.
module cordic_result_fifo
  import cordic_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    push_i,
  input  result_t data_i,
  input  logic    pop_i,
  output result_t data_o,
  output logic    full_o,
  output logic    empty_o,
  output logic [AW:0] count_o,
  output logic    drop_o
);

  result_t       mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // A pop frees the slot in the same edge, so a push while full still lands.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && full_o && !do_pop;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_q] <= data_i;
  end

  assign data_o = empty_o ? '0 : mem[rd_q];

endmodule

// File: rtl/cordic_gain_comp.sv
// Removes the mode-dependent CORDIC gain from x/y (multiply, round, saturate) and buffers results.
module cordic_gain_comp
  import cordic_pkg::*;
#(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] GAIN_CIRC  = GAIN_CIRC_Q16,
  parameter logic [31:0] GAIN_HYPER = GAIN_HYPER_Q16
) (
  input logic clk_i,
  input logic rst_i,
  cordic_gain_comp_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic signed [63:0] R_MAX = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [63:0] R_MIN = 64'shFFFF_FFFF_8000_0000;

  function automatic logic signed [63:0] round_half_up(input logic signed [63:0] p);
    return (p + 64'sh8000) >>> Q_FRAC;
  endfunction

  function automatic logic is_sat(input logic signed [63:0] r);
    return (r > R_MAX) || (r < R_MIN);
  endfunction

  function automatic logic signed [31:0] sat32(input logic signed [63:0] r);
    if (r > R_MAX)      return 32'sh7FFF_FFFF;
    else if (r < R_MIN) return 32'sh8000_0000;
    else                return r[31:0];
  endfunction

  logic               vld_p0, vld_p1, vld_p2;
  logic signed [31:0] x_p0, y_p0, g_p0;
  logic [31:0]        z_p0, z_p1, z_p2;
  mode_e              mode_p0, mode_p1, mode_p2;
  logic signed [63:0] px_p1, py_p1;
  logic signed [63:0] rx, ry;
  logic signed [31:0] x_p2, y_p2;
  logic               sat_p2;
  logic [31:0]        g_sel;

  always_comb begin
    g_sel = GAIN_UNITY_Q16;
    case (bus.mode_i)
      CIRCULAR:   g_sel = GAIN_CIRC;
      HYPERBOLIC: g_sel = GAIN_HYPER;
      default:    g_sel = GAIN_UNITY_Q16;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p0 <= bus.valid_i;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  assign rx = round_half_up(px_p1);
  assign ry = round_half_up(py_p1);

  always_ff @(posedge clk_i) begin
    // p0: capture core result and selected gain
    x_p0    <= bus.x_i;
    y_p0    <= bus.y_i;
    z_p0    <= bus.z_i;
    mode_p0 <= mode_e'(bus.mode_i);
    g_p0    <= g_sel;
    // p1: full-precision products
    px_p1   <= 64'(x_p0) * 64'(g_p0);
    py_p1   <= 64'(y_p0) * 64'(g_p0);
    z_p1    <= z_p0;
    mode_p1 <= mode_p0;
    // p2: round back to Q16.16 and clamp
    x_p2    <= sat32(rx);
    y_p2    <= sat32(ry);
    sat_p2  <= is_sat(rx) || is_sat(ry);
    z_p2    <= z_p1;
    mode_p2 <= mode_p1;
  end

  result_t        wr_data, head;
  logic           fifo_full, fifo_empty, fifo_drop;
  logic [CW-1:0]  fifo_count;
  logic           overflow_q, overflow_d;
  logic           unused_fifo_status;

  assign wr_data = '{mode: mode_p2, sat: sat_p2, x: x_p2, y: y_p2, z: z_p2};

  cordic_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (vld_p2),
    .data_i  (wr_data),
    .pop_i   (bus.ready_i),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .drop_o  (fifo_drop)
  );

  assign unused_fifo_status = ^{fifo_full, fifo_count};
  assign overflow_d = overflow_q || fifo_drop;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) overflow_q <= 1'b0;
    else       overflow_q <= overflow_d;
  end

  assign bus.valid_o    = !fifo_empty;
  assign bus.x_o        = head.x;
  assign bus.y_o        = head.y;
  assign bus.z_o        = head.z;
  assign bus.mode_o     = head.mode;
  assign bus.sat_o      = head.sat;
  assign bus.overflow_o = overflow_q;

endmodule

// File: tb/tb_cordic_gain_comp.sv
// Directed bench for cordic_gain_comp with a queue-based reference model checked every cycle.
module tb_cordic_gain_comp;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cordic_gain_comp_if bus ();

  cordic_gain_comp #(.DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  mode;
    logic        sat;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
  } exp_t;

  typedef struct {
    int   due;
    exp_t r;
  } fly_t;

  exp_t mq[$];
  fly_t pq[$];
  logic m_ovf = 1'b0;
  int   edge_n = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec arithmetic: multiply by 1/K, add half an LSB, floor-shift, clamp to 32 bits.
  function automatic logic [31:0] scale(input logic [1:0] mode, input logic [31:0] v, output logic s);
    longint g, p, r;
    g = (mode == 2'b00) ? 64'sd39797 : (mode == 2'b10) ? 64'sd79134 : 64'sd65536;
    p = longint'($signed(v)) * g;
    r = (p + 64'sd32768) >>> 16;
    if (r > 64'sd2147483647) begin
      s = 1'b1;
      return 32'h7FFF_FFFF;
    end else if (r < -64'sd2147483648) begin
      s = 1'b1;
      return 32'h8000_0000;
    end
    s = 1'b0;
    return r[31:0];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      pq.delete();
      m_ovf = 1'b0;
    end else begin
      fly_t f;
      logic sx, sy;
      edge_n++;
      if (mq.size() > 0 && bus.ready_i) void'(mq.pop_front());
      while (pq.size() > 0 && pq[0].due == edge_n) begin
        f = pq.pop_front();
        if (mq.size() < DEPTH) mq.push_back(f.r);
        else m_ovf = 1'b1;
      end
      if (bus.valid_i) begin
        f.due    = edge_n + 3;
        f.r.mode = bus.mode_i;
        f.r.x    = scale(bus.mode_i, bus.x_i, sx);
        f.r.y    = scale(bus.mode_i, bus.y_i, sy);
        f.r.z    = bus.z_i;
        f.r.sat  = sx | sy;
        pq.push_back(f);
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("rst_valid_o", 32'(bus.valid_o), 32'd0);
      check("rst_x_o", bus.x_o, 32'd0);
      check("rst_y_o", bus.y_o, 32'd0);
      check("rst_z_o", bus.z_o, 32'd0);
      check("rst_mode_o", 32'(bus.mode_o), 32'd0);
      check("rst_sat_o", 32'(bus.sat_o), 32'd0);
      check("rst_overflow_o", 32'(bus.overflow_o), 32'd0);
    end else begin
      check("valid_o", 32'(bus.valid_o), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        check("x_o", bus.x_o, mq[0].x);
        check("y_o", bus.y_o, mq[0].y);
        check("z_o", bus.z_o, mq[0].z);
        check("mode_o", 32'(bus.mode_o), 32'(mq[0].mode));
        check("sat_o", 32'(bus.sat_o), 32'(mq[0].sat));
      end
      check("overflow_o", 32'(bus.overflow_o), 32'(m_ovf));
    end
  end

  task automatic send(input logic [1:0] m, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] z);
    bus.valid_i = 1'b1;
    bus.mode_i  = m;
    bus.x_i     = x;
    bus.y_i     = y;
    bus.z_i     = z;
    @(negedge clk);
    bus.valid_i = 1'b0;
  endtask

  task automatic run_one(input string name, input logic [1:0] m, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] ex, input logic [31:0] ey,
                         input logic es);
    send(m, x, y, 32'h0000_C910);
    repeat (2) @(negedge clk);
    check({name, "_early"}, 32'(bus.valid_o), 32'd0);
    @(negedge clk);
    check({name, "_valid"}, 32'(bus.valid_o), 32'd1);
    check({name, "_x"}, bus.x_o, ex);
    check({name, "_y"}, bus.y_o, ey);
    check({name, "_z"}, bus.z_o, 32'h0000_C910);
    check({name, "_sat"}, 32'(bus.sat_o), 32'(es));
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_rst_valid", 32'(bus.valid_o), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst         = 1'b1;
    bus.valid_i = 1'b0;
    bus.mode_i  = 2'b00;
    bus.x_i     = '0;
    bus.y_i     = '0;
    bus.z_i     = '0;
    bus.ready_i = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    run_one("circ",  2'b00, 32'h0001_0000, 32'h0,         32'h0000_9B75, 32'h0,         1'b0);
    run_one("neg",   2'b00, 32'hFFFF_0000, 32'h0,         32'hFFFF_648B, 32'h0,         1'b0);
    run_one("hyper", 2'b10, 32'h0001_0000, 32'h0,         32'h0001_351E, 32'h0,         1'b0);
    run_one("lin",   2'b01, 32'h1234_5678, 32'h0,         32'h1234_5678, 32'h0,         1'b0);
    run_one("sat",   2'b10, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
    run_one("rsv",   2'b11, 32'hDEAD_BEEF, 32'h0000_0001, 32'hDEAD_BEEF, 32'h0000_0001, 1'b0);

    // back-to-back mixed vectors, checked by the model only
    send(2'b00, 32'h0000_0001, 32'h0000_8000, 32'h1);
    send(2'b10, 32'hFFFF_FFFF, 32'h4000_0000, 32'h2);
    send(2'b00, 32'h8000_0000, 32'h7FFF_FFFF, 32'h3);
    send(2'b10, 32'hC000_0000, 32'hFFFF_8000, 32'h4);
    repeat (8) @(negedge clk);

    // backpressure and overflow
    bus.ready_i = 1'b0;
    for (int k = 1; k <= 5; k++) send(2'b01, 32'(k) << 16, 32'h0, 32'(k));
    repeat (5) @(negedge clk);
    check("ovf_valid", 32'(bus.valid_o), 32'd1);
    check("ovf_flag", 32'(bus.overflow_o), 32'd1);
    check("ovf_head", bus.x_o, 32'h0001_0000);
    repeat (3) @(negedge clk);
    check("ovf_head_stable", bus.x_o, 32'h0001_0000);
    bus.ready_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("drain_x", bus.x_o, 32'(k) << 16);
      @(negedge clk);
    end
    check("drain_empty", 32'(bus.valid_o), 32'd0);
    check("ovf_sticky", 32'(bus.overflow_o), 32'd1);

    pulse_reset();
    check("ovf_cleared", 32'(bus.overflow_o), 32'd0);

    // full FIFO with push and pop on the same edges
    bus.ready_i = 1'b0;
    for (int k = 10; k <= 13; k++) send(2'b01, 32'(k) << 16, 32'h0, 32'(k));
    repeat (5) @(negedge clk);
    check("full_valid", 32'(bus.valid_o), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) bus.ready_i = 1'b1;
      if (i == 4) check("full_pp_head", bus.x_o, 32'h000B_0000);
      send(2'b00, 32'(20 + i) << 16, 32'(i) << 12, 32'(20 + i));
    end
    check("full_pp_no_ovf", 32'(bus.overflow_o), 32'd0);
    repeat (20) @(negedge clk);
    check("full_pp_drained", 32'(bus.valid_o), 32'd0);
    check("full_pp_ovf_end", 32'(bus.overflow_o), 32'd0);

    // reset with two buffered and two in flight
    bus.ready_i = 1'b0;
    send(2'b01, 32'h001E_0000, 32'h0, 32'd30);
    send(2'b01, 32'h001F_0000, 32'h0, 32'd31);
    repeat (4) @(negedge clk);
    send(2'b01, 32'h0020_0000, 32'h0, 32'd32);
    send(2'b01, 32'h0021_0000, 32'h0, 32'd33);
    check("pre_rst_valid", 32'(bus.valid_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(bus.valid_o), 32'd0);
    check("mid_rst_x", bus.x_o, 32'd0);
    check("mid_rst_ovf", 32'(bus.overflow_o), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    bus.ready_i = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_quiet", 32'(bus.valid_o), 32'd0);
    run_one("post_rst", 2'b01, 32'h0028_0000, 32'h0, 32'h0028_0000, 32'h0, 1'b0);
    check("post_rst_ovf", 32'(bus.overflow_o), 32'd0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
